// File: rtl/phase_sequencer_pkg.sv
// Shared phase codes, state type and defaults for the phase sequencer.
package phase_sequencer_pkg;

  localparam int unsigned PHASE_W            = 3;
  localparam int unsigned EXEC_W             = 2;
  localparam int unsigned WAIT_LIMIT_DEFAULT = 15;
  localparam int unsigned COUNT_W_DEFAULT    = 16;

  // Encoded phase values driven on the phase output; IDLE must stay 0.
  localparam logic [PHASE_W-1:0] PH_IDLE      = 3'd0;
  localparam logic [PHASE_W-1:0] PH_FETCH     = 3'd1;
  localparam logic [PHASE_W-1:0] PH_DECODE    = 3'd2;
  localparam logic [PHASE_W-1:0] PH_EXECUTE   = 3'd3;
  localparam logic [PHASE_W-1:0] PH_INCREMENT = 3'd4;
  localparam logic [PHASE_W-1:0] PH_PAUSE     = 3'd5;
  localparam logic [PHASE_W-1:0] PH_HALT      = 3'd6;
  localparam logic [PHASE_W-1:0] PH_FAULT     = 3'd7;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE      = PH_IDLE,
    ST_FETCH     = PH_FETCH,
    ST_DECODE    = PH_DECODE,
    ST_EXECUTE   = PH_EXECUTE,
    ST_INCREMENT = PH_INCREMENT,
    ST_PAUSE     = PH_PAUSE,
    ST_HALT      = PH_HALT,
    ST_FAULT     = PH_FAULT
  } state_t;

  // Decoder exec length field: a zero length still executes for one cycle.
  function automatic logic [EXEC_W-1:0] exec_len(input logic [EXEC_W-1:0] raw);
    return (raw == EXEC_W'(0)) ? EXEC_W'(1) : raw;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control inputs and status outputs of the phase sequencer.
interface phase_sequencer_if #(
  parameter int unsigned COUNT_W = phase_sequencer_pkg::COUNT_W_DEFAULT
);

  logic                                     run;
  logic                                     step_mode;
  logic                                     step;
  logic                                     mem_ready;
  logic                                     halt_op;
  logic [phase_sequencer_pkg::EXEC_W-1:0]   exec_cycles;
  logic                                     resume;

  logic                                     fetch;
  logic                                     decode;
  logic                                     execute;
  logic                                     increment;
  logic [phase_sequencer_pkg::PHASE_W-1:0]  phase;
  logic                                     halted;
  logic                                     fault;
  logic [COUNT_W-1:0]                       instr_count;

  // Controller side: drives the control inputs, observes status.
  modport master (
    output run, step_mode, step, mem_ready, halt_op, exec_cycles, resume,
    input  fetch, decode, execute, increment, phase, halted, fault, instr_count
  );

  // Sequencer side.
  modport slave (
    input  run, step_mode, step, mem_ready, halt_op, exec_cycles, resume,
    output fetch, decode, execute, increment, phase, halted, fault, instr_count
  );

endinterface

// File: rtl/phase_sequencer_wait_timer.sv
// Wait timer: saturating count of consecutive stalled FETCH cycles.
module phase_sequencer_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clock,
  input  logic clear,
  input  logic restart,
  input  logic enable,
  output logic hit_c
);

  localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;

  // Count enabled cycles, holding at LIMIT; restart or reset returns to zero.
  always_ff @(posedge clock) begin
    if (!clear || restart) begin
      count_q <= '0;
    end else if (enable && (count_q != CNT_W'(LIMIT))) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // High during the LIMIT-th consecutive enabled cycle.
  assign hit_c = enable && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: fetch/decode/execute/increment with
// single-step, halt and fetch-timeout fault handling.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT,
  parameter int unsigned COUNT_W    = COUNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  phase_sequencer_if.slave bus
);

  state_t              state_q;
  state_t              state_d;
  logic [EXEC_W-1:0]   exec_len_q;
  logic [EXEC_W-1:0]   exec_cnt_q;
  logic [COUNT_W-1:0]  count_q;
  logic                wait_hit_c;

  // Timer is held cleared outside FETCH, so every FETCH entry starts at zero.
  phase_sequencer_wait_timer #(
    .LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clock   (clock),
    .clear   (clear),
    .restart (state_q != ST_FETCH),
    .enable  ((state_q == ST_FETCH) && !bus.mem_ready),
    .hit_c   (wait_hit_c)
  );

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.mem_ready)   state_d = ST_DECODE;
        else if (wait_hit_c) state_d = ST_FAULT;
      end
      ST_DECODE: begin
        state_d = bus.halt_op ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (exec_cnt_q >= exec_len_q) state_d = ST_INCREMENT;
      end
      ST_INCREMENT: begin
        if (bus.step_mode) state_d = ST_PAUSE;
        else if (!bus.run) state_d = ST_IDLE;
        else               state_d = ST_FETCH;
      end
      ST_PAUSE: begin
        if (!bus.run)                         state_d = ST_IDLE;
        else if (bus.step || !bus.step_mode)  state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (bus.resume) state_d = ST_INCREMENT;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, exec length/count, retired count and registered Moore outputs.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q       <= ST_IDLE;
      exec_len_q    <= EXEC_W'(1);
      exec_cnt_q    <= EXEC_W'(1);
      count_q       <= '0;
      bus.fetch     <= 1'b0;
      bus.decode    <= 1'b0;
      bus.execute   <= 1'b0;
      bus.increment <= 1'b0;
      bus.halted    <= 1'b0;
      bus.fault     <= 1'b0;
      bus.phase     <= PH_IDLE;
    end else begin
      state_q       <= state_d;
      bus.fetch     <= (state_d == ST_FETCH);
      bus.decode    <= (state_d == ST_DECODE);
      bus.execute   <= (state_d == ST_EXECUTE);
      bus.increment <= (state_d == ST_INCREMENT);
      bus.halted    <= (state_d == ST_HALT);
      bus.fault     <= (state_d == ST_FAULT);
      bus.phase     <= PHASE_W'(state_d);

      if (state_q == ST_DECODE) begin
        exec_len_q <= exec_len(bus.exec_cycles);
        exec_cnt_q <= EXEC_W'(1);
      end else if (state_q == ST_EXECUTE) begin
        exec_cnt_q <= exec_cnt_q + EXEC_W'(1);
      end

      // Count updates together with the increment strobe.
      if (state_d == ST_INCREMENT) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: expected phase/count per cycle is
// queued when inputs are applied and checked after the following edge.
module tb_phase_sequencer;
  import phase_sequencer_pkg::*;

  localparam int unsigned COUNT_W    = 8;
  localparam int unsigned WAIT_LIMIT = 15;

  typedef struct {
    logic [PHASE_W-1:0] ph;
    logic [COUNT_W-1:0] cnt;
  } exp_t;

  logic clock = 1'b0;
  logic clear;

  exp_t               sb[$];
  logic [COUNT_W-1:0] exp_cnt;
  int                 total = 0;
  int                 bad   = 0;

  phase_sequencer_if #(.COUNT_W(COUNT_W)) bus ();

  phase_sequencer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .COUNT_W    (COUNT_W)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, got, want);
    end
  endtask

  // {fetch, decode, execute, increment, halted, fault} for a phase code.
  function automatic logic [5:0] strobes_for(input logic [PHASE_W-1:0] ph);
    case (ph)
      PH_FETCH:     return 6'b100000;
      PH_DECODE:    return 6'b010000;
      PH_EXECUTE:   return 6'b001000;
      PH_INCREMENT: return 6'b000100;
      PH_HALT:      return 6'b000010;
      PH_FAULT:     return 6'b000001;
      default:      return 6'b000000;
    endcase
  endfunction

  // Queue the expectation for the next edge, advance one cycle, check it.
  task automatic cyc(input logic [PHASE_W-1:0] ph);
    exp_t e;
    sb.push_back('{ph: ph, cnt: exp_cnt});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("phase", 32'(bus.phase), 32'(e.ph));
    chk("strobes", 32'({bus.fetch, bus.decode, bus.execute, bus.increment,
                        bus.halted, bus.fault}), 32'(strobes_for(e.ph)));
    chk("count", 32'(bus.instr_count), 32'(e.cnt));
  endtask

  // One full instruction starting with a FETCH on the next edge.
  task automatic run_instr(input logic [1:0] ec);
    int n;
    bus.exec_cycles = ec;
    bus.mem_ready   = 1'b1;
    bus.halt_op     = 1'b0;
    n = (ec == 2'd0) ? 1 : int'(ec);
    cyc(PH_FETCH);
    cyc(PH_DECODE);
    for (int i = 0; i < n; i++) cyc(PH_EXECUTE);
    exp_cnt = exp_cnt + 1'b1;
    cyc(PH_INCREMENT);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear           = 1'b0;
    bus.run         = 1'b1;
    bus.step_mode   = 1'b0;
    bus.step        = 1'b0;
    bus.mem_ready   = 1'b1;
    bus.halt_op     = 1'b0;
    bus.exec_cycles = 2'd2;
    bus.resume      = 1'b0;
    exp_cnt         = '0;

    // Reset holds IDLE even with run asserted.
    cyc(PH_IDLE);
    cyc(PH_IDLE);

    // Three instructions with two execute cycles each, back to back.
    clear = 1'b1;
    for (int k = 0; k < 3; k++) run_instr(2'd2);
    bus.run = 1'b0;
    cyc(PH_IDLE);

    // Stray resume/step in IDLE are ignored.
    bus.resume = 1'b1;
    bus.step   = 1'b1;
    cyc(PH_IDLE);
    bus.resume = 1'b0;
    bus.step   = 1'b0;

    // run dropped during FETCH: instruction still completes; exec 0 -> 1 cycle.
    bus.run         = 1'b1;
    bus.exec_cycles = 2'd0;
    cyc(PH_FETCH);
    bus.run = 1'b0;
    cyc(PH_DECODE);
    cyc(PH_EXECUTE);
    exp_cnt = exp_cnt + 1'b1;
    cyc(PH_INCREMENT);
    cyc(PH_IDLE);

    // Three execute cycles.
    bus.run = 1'b1;
    run_instr(2'd3);
    bus.run = 1'b0;
    cyc(PH_IDLE);

    // mem_ready low for WAIT_LIMIT-1 cycles, then high: no fault.
    bus.run       = 1'b1;
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 15; k++) cyc(PH_FETCH);
    bus.mem_ready   = 1'b1;
    bus.exec_cycles = 2'd1;
    cyc(PH_DECODE);
    cyc(PH_EXECUTE);
    exp_cnt = exp_cnt + 1'b1;
    cyc(PH_INCREMENT);
    bus.run = 1'b0;
    cyc(PH_IDLE);

    // mem_ready low for WAIT_LIMIT cycles: FAULT on the 16th cycle, sticky.
    bus.run       = 1'b1;
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 15; k++) cyc(PH_FETCH);
    cyc(PH_FAULT);
    bus.mem_ready = 1'b1;
    bus.resume    = 1'b1;
    bus.step      = 1'b1;
    for (int k = 0; k < 5; k++) cyc(PH_FAULT);
    bus.resume = 1'b0;
    bus.step   = 1'b0;
    clear      = 1'b0;
    exp_cnt    = '0;
    cyc(PH_IDLE);
    clear   = 1'b1;
    bus.run = 1'b0;
    cyc(PH_IDLE);

    // HALT held 20 cycles regardless of run/step, resume retires it.
    bus.run     = 1'b1;
    bus.halt_op = 1'b1;
    cyc(PH_FETCH);
    cyc(PH_DECODE);
    cyc(PH_HALT);
    bus.halt_op     = 1'b0;
    bus.exec_cycles = 2'd1;
    for (int k = 0; k < 20; k++) begin
      bus.run  = (k % 2) == 0;
      bus.step = (k == 5);
      cyc(PH_HALT);
    end
    bus.step   = 1'b0;
    bus.run    = 1'b1;
    bus.resume = 1'b1;
    exp_cnt    = exp_cnt + 1'b1;
    cyc(PH_INCREMENT);
    bus.resume = 1'b0;
    cyc(PH_FETCH);
    cyc(PH_DECODE);
    cyc(PH_EXECUTE);
    exp_cnt = exp_cnt + 1'b1;
    cyc(PH_INCREMENT);
    bus.run = 1'b0;
    cyc(PH_IDLE);

    // Single-step: step held during an instruction is not remembered.
    bus.run       = 1'b1;
    bus.step_mode = 1'b1;
    bus.step      = 1'b1;
    run_instr(2'd1);
    cyc(PH_PAUSE);
    bus.step = 1'b0;
    for (int k = 0; k < 10; k++) cyc(PH_PAUSE);
    bus.step = 1'b1;
    cyc(PH_FETCH);
    bus.step = 1'b0;
    cyc(PH_DECODE);
    cyc(PH_EXECUTE);
    exp_cnt = exp_cnt + 1'b1;
    cyc(PH_INCREMENT);
    cyc(PH_PAUSE);
    cyc(PH_PAUSE);
    // Leaving step mode resumes free running.
    bus.step_mode = 1'b0;
    cyc(PH_FETCH);
    bus.step_mode = 1'b1;
    cyc(PH_DECODE);
    cyc(PH_EXECUTE);
    exp_cnt = exp_cnt + 1'b1;
    cyc(PH_INCREMENT);
    cyc(PH_PAUSE);
    // step together with run low goes to IDLE.
    bus.step = 1'b1;
    bus.run  = 1'b0;
    cyc(PH_IDLE);
    bus.step      = 1'b0;
    bus.step_mode = 1'b0;

    // Run the counter up through all-ones and across the wrap to zero.
    bus.run = 1'b1;
    do begin
      run_instr(2'd1);
    end while (exp_cnt != '0);
    chk("wrap", 32'(bus.instr_count), 32'd0);

    // Reset mid-EXECUTE, then restart on the first released edge.
    bus.exec_cycles = 2'd3;
    cyc(PH_FETCH);
    cyc(PH_DECODE);
    cyc(PH_EXECUTE);
    clear   = 1'b0;
    exp_cnt = '0;
    cyc(PH_IDLE);
    clear = 1'b1;
    cyc(PH_FETCH);
    bus.run = 1'b0;
    cyc(PH_DECODE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
